// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types for the run-control / exit monitor.
//   run_state_e : top-level FSM states (HOLD -> RUN -> DONE)
//   exit_mode_e : end-of-run policy (any enabled channel / all enabled channels)
//   verdict_e   : final verdict classes
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    typedef enum logic {
        EXIT_ANY = 1'b0,
        EXIT_ALL = 1'b1
    } exit_mode_e;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        FAIL    = 2'd1,
        TIMEOUT = 2'd2
    } verdict_e;

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl_ch.sv
// ---------------------------------------------------------------------------
// run_ctrl_ch
// One exit-reporting channel: a sticky "exited" flag, the captured exit
// value and a flag telling whether that value was nonzero. Only the first
// enabled strobe seen while the run is active is captured.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clear           synchronous clear of flag and capture
//   i_run             top FSM is in RUN (strobes outside RUN are ignored)
//   i_en              channel enable
//   i_valid, i_value  exit strobe and value
//   o_exited_next     flag as it will be after this edge (registered | capture)
//   o_nonzero_next    nonzero flag as it will be after this edge
//   o_value_next      captured value as it will be after this edge
// ---------------------------------------------------------------------------
module run_ctrl_ch
    import run_ctrl_pkg::*;
#(
    parameter int VALUE_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic               i_en,
    input  logic               i_valid,
    input  logic [VALUE_W-1:0] i_value,
    output logic               o_exited_next,
    output logic               o_nonzero_next,
    output logic [VALUE_W-1:0] o_value_next
);

    logic               r_exited;
    logic               r_nonzero;
    logic [VALUE_W-1:0] r_value;
    logic               w_capture;

    // Later strobes on an already-exited channel are dropped.
    assign w_capture = i_run & i_en & i_valid & ~r_exited;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exited  <= 1'b0;
            r_nonzero <= 1'b0;
            r_value   <= '0;
        end else if (i_clear) begin
            r_exited  <= 1'b0;
            r_nonzero <= 1'b0;
            r_value   <= '0;
        end else if (w_capture) begin
            r_exited  <= 1'b1;
            r_nonzero <= |i_value;
            r_value   <= i_value;
        end
    end

    // Look-ahead views let the top decide the verdict on the same edge the
    // strobe is captured, giving a one-cycle strobe-to-verdict latency.
    assign o_exited_next  = r_exited | w_capture;
    assign o_nonzero_next = w_capture ? (|i_value) : r_nonzero;
    assign o_value_next   = w_capture ? i_value : r_value;

endmodule : run_ctrl_ch

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
// Run-control and exit monitor. Holds the core in reset for RST_HOLD_CYCLES
// edges, latches the boot straps when releasing it, then watches NUM_CH exit
// channels and a programmable cycle watchdog, and reports one sticky
// registered verdict (pass / fail / timeout).
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   clear_i                  synchronous restart into HOLD
//   boot_sel_i               boot strap (0 jtag, 1 flash)
//   execute_from_flash_i     SPI strap
//   exit_mode_i              0 any enabled channel ends run, 1 all must exit
//   ch_en_i                  channel enable mask
//   max_cycles_i             watchdog limit, 0 disables
//   exit_valid_i             per-channel exit strobe
//   exit_value_i             per-channel exit value, channel k at [k*VALUE_W +: VALUE_W]
//   core_rst_no              active-low core reset
//   boot_sel_o,
//   execute_from_flash_o     straps latched at HOLD->RUN
//   done_o                   verdict valid (sticky)
//   pass_o, fail_o, timeout_o one-hot verdict
//   fail_ch_o                lowest failing channel
//   result_value_o           exit value of fail_ch_o on fail, else 0
//   cycle_cnt_o              RUN cycles elapsed (saturating, frozen in DONE)
// ---------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int VALUE_W         = 32,
    parameter int CNT_W           = 32,
    parameter int RST_HOLD_CYCLES = 50,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      boot_sel_i,
    input  logic                      execute_from_flash_i,
    input  logic                      exit_mode_i,
    input  logic [NUM_CH-1:0]         ch_en_i,
    input  logic [CNT_W-1:0]          max_cycles_i,
    input  logic [NUM_CH-1:0]         exit_valid_i,
    input  logic [NUM_CH*VALUE_W-1:0] exit_value_i,
    output logic                      core_rst_no,
    output logic                      boot_sel_o,
    output logic                      execute_from_flash_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic                      timeout_o,
    output logic [CH_W-1:0]           fail_ch_o,
    output logic [VALUE_W-1:0]        result_value_o,
    output logic [CNT_W-1:0]          cycle_cnt_o
);

    // A counter of $clog2(N) bits holds N-1, the last hold count.
    localparam int                 HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    run_state_e         r_state;
    run_state_e         w_state_next;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]   r_cycle_cnt;

    // Registered outputs and their next values
    logic               r_core_rst_n,  w_core_rst_n_next;
    logic               r_boot_sel,    w_boot_sel_next;
    logic               r_exec_flash,  w_exec_flash_next;
    logic               r_done,        w_done_next;
    logic               r_pass,        w_pass_next;
    logic               r_fail,        w_fail_next;
    logic               r_timeout,     w_timeout_next;
    logic [CH_W-1:0]    r_fail_ch,     w_fail_ch_next;
    logic [VALUE_W-1:0] r_result,      w_result_next;

    // Channel look-ahead views
    logic [NUM_CH-1:0]  w_exited_next;
    logic [NUM_CH-1:0]  w_nonzero_next;
    logic [VALUE_W-1:0] w_value_next [NUM_CH];

    logic               w_run;
    logic               w_hold_done;
    logic [NUM_CH-1:0]  w_exited_en;
    logic [NUM_CH-1:0]  w_fail_vec;
    logic               w_end;
    logic               w_wdog;
    logic               w_run_ends;
    exit_mode_e         w_mode;
    verdict_e           w_verdict;
    logic [CH_W-1:0]    w_fail_ch;
    logic [VALUE_W-1:0] w_fail_value;

    assign w_run       = (r_state == RUN);
    assign w_hold_done = (r_state == HOLD) && (r_hold_cnt == HOLD_LAST);
    assign w_mode      = exit_mode_e'(exit_mode_i);

    // ------------------------------------------------------------------
    // Exit channels
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            run_ctrl_ch #(
                .VALUE_W (VALUE_W)
            ) u_ch (
                .i_clk          (clk_i),
                .i_rst          (rst_i),
                .i_clear        (clear_i),
                .i_run          (w_run),
                .i_en           (ch_en_i[gi]),
                .i_valid        (exit_valid_i[gi]),
                .i_value        (exit_value_i[gi*VALUE_W +: VALUE_W]),
                .o_exited_next  (w_exited_next[gi]),
                .o_nonzero_next (w_nonzero_next[gi]),
                .o_value_next   (w_value_next[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // End condition, watchdog and verdict
    // ------------------------------------------------------------------
    // The mask is applied live, so a channel disabled after exiting no
    // longer counts towards the end condition or the verdict.
    assign w_exited_en = w_exited_next & ch_en_i;
    assign w_fail_vec  = w_exited_en & w_nonzero_next;

    // In ALL mode an empty mask compares equal immediately and ends the run.
    assign w_end = (w_mode == EXIT_ANY) ? (|w_exited_en)
                                        : (w_exited_en == ch_en_i);

    assign w_wdog     = (max_cycles_i != '0) && (r_cycle_cnt >= max_cycles_i);
    assign w_run_ends = w_run && (w_end || w_wdog);

    // Lowest failing index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_fail_ch    = '0;
        w_fail_value = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_fail_vec[k]) begin
                w_fail_ch    = CH_W'(k);
                w_fail_value = w_value_next[k];
            end
        end
    end

    // An end condition takes priority over the watchdog.
    always_comb begin
        if (w_end) begin
            w_verdict = (|w_fail_vec) ? FAIL : PASS;
        end else begin
            w_verdict = TIMEOUT;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = HOLD;
        end else begin
            case (r_state)
                HOLD:    if (w_hold_done) w_state_next = RUN;
                RUN:     if (w_run_ends)  w_state_next = DONE;
                DONE:    w_state_next = DONE;
                default: w_state_next = HOLD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_core_rst_n_next = (w_state_next != HOLD);
        w_boot_sel_next   = r_boot_sel;
        w_exec_flash_next = r_exec_flash;
        w_done_next       = r_done;
        w_pass_next       = r_pass;
        w_fail_next       = r_fail;
        w_timeout_next    = r_timeout;
        w_fail_ch_next    = r_fail_ch;
        w_result_next     = r_result;

        if (clear_i) begin
            w_boot_sel_next   = 1'b0;
            w_exec_flash_next = 1'b0;
            w_done_next       = 1'b0;
            w_pass_next       = 1'b0;
            w_fail_next       = 1'b0;
            w_timeout_next    = 1'b0;
            w_fail_ch_next    = '0;
            w_result_next     = '0;
        end else begin
            // Straps are taken on the same edge the core leaves reset.
            if (w_hold_done) begin
                w_boot_sel_next   = boot_sel_i;
                w_exec_flash_next = execute_from_flash_i;
            end
            if (w_run_ends) begin
                w_done_next    = 1'b1;
                w_pass_next    = (w_verdict == PASS);
                w_fail_next    = (w_verdict == FAIL);
                w_timeout_next = (w_verdict == TIMEOUT);
                w_fail_ch_next = (w_verdict == FAIL) ? w_fail_ch : '0;
                w_result_next  = (w_verdict == FAIL) ? w_fail_value : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_core_rst_n <= 1'b0;
            r_boot_sel   <= 1'b0;
            r_exec_flash <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_ch    <= '0;
            r_result     <= '0;
        end else begin
            r_core_rst_n <= w_core_rst_n_next;
            r_boot_sel   <= w_boot_sel_next;
            r_exec_flash <= w_exec_flash_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_fail       <= w_fail_next;
            r_timeout    <= w_timeout_next;
            r_fail_ch    <= w_fail_ch_next;
            r_result     <= w_result_next;
        end
    end

    // ------------------------------------------------------------------
    // Hold and cycle counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_cnt <= '0;
        end else if (clear_i || (r_state != HOLD)) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // Counts every RUN edge (including the one entering DONE), saturates,
    // and freezes in DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle_cnt <= '0;
        end else if (clear_i || (r_state == HOLD)) begin
            r_cycle_cnt <= '0;
        end else if (w_run && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign core_rst_no          = r_core_rst_n;
    assign boot_sel_o           = r_boot_sel;
    assign execute_from_flash_o = r_exec_flash;
    assign done_o               = r_done;
    assign pass_o               = r_pass;
    assign fail_o               = r_fail;
    assign timeout_o            = r_timeout;
    assign fail_ch_o            = r_fail_ch;
    assign result_value_o       = r_result;
    assign cycle_cnt_o          = r_cycle_cnt;

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
// Directed bench for run_ctrl with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int NUM_CH  = 2;
    localparam int VALUE_W = 32;
    localparam int CNT_W   = 32;
    localparam int HOLD    = 50;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      clear_i;
    logic                      boot_sel_i;
    logic                      execute_from_flash_i;
    logic                      exit_mode_i;
    logic [NUM_CH-1:0]         ch_en_i;
    logic [CNT_W-1:0]          max_cycles_i;
    logic [NUM_CH-1:0]         exit_valid_i;
    logic [NUM_CH*VALUE_W-1:0] exit_value_i;
    logic                      core_rst_no;
    logic                      boot_sel_o;
    logic                      execute_from_flash_o;
    logic                      done_o;
    logic                      pass_o;
    logic                      fail_o;
    logic                      timeout_o;
    logic [0:0]                fail_ch_o;
    logic [VALUE_W-1:0]        result_value_o;
    logic [CNT_W-1:0]          cycle_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    run_ctrl #(
        .NUM_CH          (NUM_CH),
        .VALUE_W         (VALUE_W),
        .CNT_W           (CNT_W),
        .RST_HOLD_CYCLES (HOLD)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .clear_i              (clear_i),
        .boot_sel_i           (boot_sel_i),
        .execute_from_flash_i (execute_from_flash_i),
        .exit_mode_i          (exit_mode_i),
        .ch_en_i              (ch_en_i),
        .max_cycles_i         (max_cycles_i),
        .exit_valid_i         (exit_valid_i),
        .exit_value_i         (exit_value_i),
        .core_rst_no          (core_rst_no),
        .boot_sel_o           (boot_sel_o),
        .execute_from_flash_o (execute_from_flash_o),
        .done_o               (done_o),
        .pass_o               (pass_o),
        .fail_o               (fail_o),
        .timeout_o            (timeout_o),
        .fail_ch_o            (fail_ch_o),
        .result_value_o       (result_value_o),
        .cycle_cnt_o          (cycle_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count edges until core_rst_no rises (bounded).
    task automatic wait_release(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (core_rst_no) break;
        end
        check(tag, 64'(n), 64'(HOLD));
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_i                = 1'b1;
        clear_i              = 1'b0;
        boot_sel_i           = 1'b1;
        execute_from_flash_i = 1'b0;
        exit_mode_i          = 1'b0;
        ch_en_i              = 2'b11;
        max_cycles_i         = '0;
        exit_valid_i         = '0;
        exit_value_i         = '0;

        // Reset state
        steps(3);
        check("rst_core_rst_no", 64'(core_rst_no), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_boot_sel", 64'(boot_sel_o), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt_o), 64'd0);

        // Reset release: exactly HOLD edges, straps latched at that edge
        rst_i = 1'b0;
        wait_release("hold_edges");
        check("strap_boot_sel", 64'(boot_sel_o), 64'd1);
        check("strap_exec_flash", 64'(execute_from_flash_o), 64'd0);
        check("first_run_cnt", 64'(cycle_cnt_o), 64'd0);

        // ANY mode: channel 1 exits with 0 at RUN cycle 20
        steps(20);
        exit_valid_i = 2'b10;
        exit_value_i = {32'd0, 32'd0};
        check("any_not_done_yet", 64'(done_o), 64'd0);
        step();
        exit_valid_i = '0;
        check("any_done", 64'(done_o), 64'd1);
        check("any_pass", 64'(pass_o), 64'd1);
        check("any_fail", 64'(fail_o), 64'd0);
        check("any_timeout", 64'(timeout_o), 64'd0);
        check("any_cnt", 64'(cycle_cnt_o), 64'd21);
        steps(3);
        check("any_cnt_frozen", 64'(cycle_cnt_o), 64'd21);
        check("any_done_sticky", 64'(done_o), 64'd1);

        // clear_i in DONE
        pulse_clear();
        check("clr_core_rst_no", 64'(core_rst_no), 64'd0);
        check("clr_done", 64'(done_o), 64'd0);
        check("clr_pass", 64'(pass_o), 64'd0);
        check("clr_cnt", 64'(cycle_cnt_o), 64'd0);
        wait_release("clr_hold_edges");

        // ALL mode: ch0 exits 0 at cycle 5, ch1 exits 3 at cycle 9
        exit_mode_i = 1'b1;
        steps(5);
        exit_valid_i = 2'b01;
        exit_value_i = {32'd0, 32'd0};
        step();
        exit_valid_i = '0;
        check("all_ch0_only_not_done", 64'(done_o), 64'd0);
        steps(3);
        exit_valid_i = 2'b10;
        exit_value_i = {32'h3, 32'd0};
        check("all_before_last", 64'(done_o), 64'd0);
        step();
        exit_valid_i = '0;
        check("all_done", 64'(done_o), 64'd1);
        check("all_fail", 64'(fail_o), 64'd1);
        check("all_pass", 64'(pass_o), 64'd0);
        check("all_fail_ch", 64'(fail_ch_o), 64'd1);
        check("all_result", 64'(result_value_o), 64'h3);
        check("all_cnt", 64'(cycle_cnt_o), 64'd10);

        // Watchdog timeout at max_cycles_i=10
        pulse_clear();
        exit_mode_i  = 1'b0;
        max_cycles_i = 32'd10;
        wait_release("wd_hold_edges");
        steps(10);
        check("wd_not_yet", 64'(done_o), 64'd0);
        step();
        check("wd_done", 64'(done_o), 64'd1);
        check("wd_timeout", 64'(timeout_o), 64'd1);
        check("wd_pass", 64'(pass_o), 64'd0);
        check("wd_cnt", 64'(cycle_cnt_o), 64'd11);

        // Exit on the watchdog cycle wins
        pulse_clear();
        wait_release("wd2_hold_edges");
        steps(10);
        exit_valid_i = 2'b01;
        exit_value_i = {32'd0, 32'd0};
        step();
        exit_valid_i = '0;
        check("wd_exit_pass", 64'(pass_o), 64'd1);
        check("wd_exit_timeout", 64'(timeout_o), 64'd0);

        // Same-cycle exits 5 and 7, then a duplicate strobe
        pulse_clear();
        max_cycles_i = '0;
        wait_release("sim_hold_edges");
        steps(3);
        exit_valid_i = 2'b11;
        exit_value_i = {32'd7, 32'd5};
        step();
        exit_valid_i = 2'b01;
        exit_value_i = {32'd0, 32'd0};
        check("sim_fail", 64'(fail_o), 64'd1);
        check("sim_fail_ch", 64'(fail_ch_o), 64'd0);
        check("sim_result", 64'(result_value_o), 64'd5);
        step();
        exit_valid_i = '0;
        check("dup_result", 64'(result_value_o), 64'd5);
        check("dup_pass", 64'(pass_o), 64'd0);

        // rst_i in DONE clears the latched verdict immediately
        rst_i = 1'b1;
        #1;
        check("rstd_done", 64'(done_o), 64'd0);
        check("rstd_fail", 64'(fail_o), 64'd0);
        check("rstd_result", 64'(result_value_o), 64'd0);
        check("rstd_boot_sel", 64'(boot_sel_o), 64'd0);
        step();
        rst_i = 1'b0;

        // Disabled channel strobe is ignored; all-zero mask in ALL mode passes at once
        ch_en_i = 2'b01;
        wait_release("dis_hold_edges");
        exit_valid_i = 2'b10;
        exit_value_i = {32'd9, 32'd0};
        step();
        exit_valid_i = '0;
        check("dis_not_done", 64'(done_o), 64'd0);
        pulse_clear();
        ch_en_i     = 2'b00;
        exit_mode_i = 1'b1;
        wait_release("zm_hold_edges");
        step();
        check("zm_done", 64'(done_o), 64'd1);
        check("zm_pass", 64'(pass_o), 64'd1);
        check("zm_cnt", 64'(cycle_cnt_o), 64'd1);

        // rst_i mid-RUN
        pulse_clear();
        ch_en_i     = 2'b11;
        exit_mode_i = 1'b0;
        wait_release("mid_hold_edges");
        steps(5);
        check("mid_cnt_before", 64'(cycle_cnt_o), 64'd5);
        rst_i = 1'b1;
        #1;
        check("mid_core_rst_no", 64'(core_rst_no), 64'd0);
        check("mid_cnt", 64'(cycle_cnt_o), 64'd0);
        steps(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_run_ctrl
